sd_init_ctrl: RTL and testbench

Sequencer for the SD-card SPI-mode bring-up. It issues CMD0, CMD8, CMD58, CMD55/ACMD41 and CMD58 to a separate bit-level command engine through a valid/ready request and a response pulse. It classifies the card (v1/v2, SDSC/SDHC), then switches the engine clock from 400 kHz to 25 MHz. It sits between the top level and the SD command engine, and it exposes init status to the future block-read logic.

---
 rtl/sd_pkg.sv | 47 ++++
 rtl/sd_init_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_sd_init_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD-card SPI-mode bring-up sequencer and its command engine.
package sd_pkg;

   typedef enum logic [3:0] {
      StIdle, StPowerup,
      StCmd0, StWCmd0,
      StCmd8, StWCmd8,
      StCmd58a, StWCmd58a,
      StCmd55, StWCmd55,
      StAcmd41, StWAcmd41,
      StCmd58b, StWCmd58b,
      StDone, StError
   } sd_state_e;

   // Complete 48-bit SPI command frames, CRC7 and end bit included
   localparam logic [47:0] FRAME_CMD0      = 48'h40_0000_0000_95;
   localparam logic [47:0] FRAME_CMD8      = 48'h48_0000_01AA_87;
   localparam logic [47:0] FRAME_CMD58     = 48'h7A_0000_0000_FD;
   localparam logic [47:0] FRAME_CMD55     = 48'h77_0000_0000_65;
   localparam logic [47:0] FRAME_ACMD41_HC = 48'h69_4000_0000_77;
   localparam logic [47:0] FRAME_ACMD41_SC = 48'h69_0000_0000_E5;

   localparam logic [5:0] RESP_LEN_R1 = 6'd8;
   localparam logic [5:0] RESP_LEN_R7 = 6'd40;

   localparam logic [7:0] R1_READY   = 8'h00;
   localparam logic [7:0] R1_IDLE    = 8'h01;
   localparam logic [7:0] R1_ILLEGAL = 8'h05;

   localparam logic [3:0] ERR_NONE   = 4'd0;
   localparam logic [3:0] ERR_CMD0   = 4'd1;
   localparam logic [3:0] ERR_CMD8   = 4'd2;
   localparam logic [3:0] ERR_CMD58A = 4'd3;
   localparam logic [3:0] ERR_CMD55  = 4'd4;
   localparam logic [3:0] ERR_ACMD41 = 4'd5;
   localparam logic [3:0] ERR_CMD58B = 4'd6;

   // Engine clock dividers from the 100 MHz system clock
   localparam int unsigned CLK_DIV_SLOW = 250;  // 400 kHz
   localparam int unsigned CLK_DIV_FAST = 4;    // 25 MHz

   // R1 that is neither ready nor idle carries an error flag
   function automatic logic r1_ok(input logic [7:0] r1);
      return (r1 == R1_READY) || (r1 == R1_IDLE);
   endfunction

endpackage

// File: rtl/sd_init_ctrl.sv
// SD-card SPI-mode init sequencer: CMD0, CMD8, CMD58, CMD55/ACMD41, CMD58, then fast clock.
module sd_init_ctrl
   import sd_pkg::*;
#(
   parameter int unsigned POWERUP_CYCLES = 1000000,
   parameter int unsigned CMD0_RETRIES   = 10,
   parameter int unsigned ACMD41_RETRIES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [47:0] cmd_frame,
   output logic [5:0]  cmd_resp_len,
   input  logic        resp_valid,
   input  logic        resp_timeout,
   input  logic [39:0] resp_data,
   output logic        cs_n,
   output logic        clk_fast,
   output logic        busy,
   output logic        init_done,
   output logic        init_error,
   output logic [3:0]  err_code,
   output logic        card_v2,
   output logic        card_hc
);

   localparam int unsigned PwrW  = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
   localparam int unsigned Cmd0W = (CMD0_RETRIES > 1)   ? $clog2(CMD0_RETRIES)   : 1;
   localparam int unsigned AcmdW = (ACMD41_RETRIES > 1) ? $clog2(ACMD41_RETRIES) : 1;

   localparam logic [PwrW-1:0]  PwrLast  = PwrW'(POWERUP_CYCLES - 1);
   localparam logic [Cmd0W-1:0] Cmd0Last = Cmd0W'(CMD0_RETRIES - 1);
   localparam logic [AcmdW-1:0] AcmdLast = AcmdW'(ACMD41_RETRIES - 1);

   sd_state_e        state_q, state_d;
   logic [PwrW-1:0]  pwr_cnt_q, pwr_cnt_d;
   logic [Cmd0W-1:0] cmd0_cnt_q, cmd0_cnt_d;
   logic [AcmdW-1:0] acmd_cnt_q, acmd_cnt_d;
   logic             card_v2_q, card_v2_d;
   logic             card_hc_q, card_hc_d;
   logic [3:0]       err_code_q, err_code_d;

   logic [7:0] r1;
   logic       unused_resp;

   assign r1          = resp_data[39:32];
   assign unused_resp = ^{resp_data[31], resp_data[29:12]};

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Counters and sticky card/status registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pwr_cnt_q  <= '0;
         cmd0_cnt_q <= '0;
         acmd_cnt_q <= '0;
         card_v2_q  <= 1'b0;
         card_hc_q  <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         pwr_cnt_q  <= pwr_cnt_d;
         cmd0_cnt_q <= cmd0_cnt_d;
         acmd_cnt_q <= acmd_cnt_d;
         card_v2_q  <= card_v2_d;
         card_hc_q  <= card_hc_d;
         err_code_q <= err_code_d;
      end
   end

   // Next-state and register update decisions
   always_comb begin
      state_d    = state_q;
      pwr_cnt_d  = pwr_cnt_q;
      cmd0_cnt_d = cmd0_cnt_q;
      acmd_cnt_d = acmd_cnt_q;
      card_v2_d  = card_v2_q;
      card_hc_d  = card_hc_q;
      err_code_d = err_code_q;

      unique case (state_q)
         StIdle, StDone, StError: begin
            if (start) begin
               state_d    = StPowerup;
               pwr_cnt_d  = '0;
               cmd0_cnt_d = '0;
               acmd_cnt_d = '0;
               card_v2_d  = 1'b0;
               card_hc_d  = 1'b0;
               err_code_d = ERR_NONE;
            end
         end
         StPowerup: begin
            if (pwr_cnt_q == PwrLast) state_d = StCmd0;
            else                      pwr_cnt_d = pwr_cnt_q + 1'b1;
         end
         StCmd0:   if (cmd_ready) state_d = StWCmd0;
         StCmd8:   if (cmd_ready) state_d = StWCmd8;
         StCmd58a: if (cmd_ready) state_d = StWCmd58a;
         StCmd55:  if (cmd_ready) state_d = StWCmd55;
         StAcmd41: if (cmd_ready) state_d = StWAcmd41;
         StCmd58b: if (cmd_ready) state_d = StWCmd58b;
         StWCmd0: begin
            if (resp_valid) begin
               if (!resp_timeout && r1 == R1_IDLE) begin
                  state_d = StCmd8;
               end else if (cmd0_cnt_q == Cmd0Last) begin
                  state_d    = StError;
                  err_code_d = ERR_CMD0;
               end else begin
                  cmd0_cnt_d = cmd0_cnt_q + 1'b1;
                  state_d    = StCmd0;
               end
            end
         end
         StWCmd8: begin
            if (resp_valid) begin
               if (!resp_timeout && r1 == R1_ILLEGAL) begin
                  card_v2_d = 1'b0;
                  state_d   = StCmd58a;
               end else if (!resp_timeout && r1 == R1_IDLE &&
                            resp_data[11:8] == 4'h1 && resp_data[7:0] == 8'hAA) begin
                  card_v2_d = 1'b1;
                  state_d   = StCmd58a;
               end else begin
                  state_d    = StError;
                  err_code_d = ERR_CMD8;
               end
            end
         end
         StWCmd58a: begin
            if (resp_valid) begin
               if (resp_timeout || !r1_ok(r1)) begin
                  state_d    = StError;
                  err_code_d = ERR_CMD58A;
               end else begin
                  state_d = StCmd55;
               end
            end
         end
         StWCmd55: begin
            if (resp_valid) begin
               if (resp_timeout || !r1_ok(r1)) begin
                  state_d    = StError;
                  err_code_d = ERR_CMD55;
               end else begin
                  state_d = StAcmd41;
               end
            end
         end
         StWAcmd41: begin
            if (resp_valid) begin
               if (!resp_timeout && r1 == R1_READY) begin
                  if (card_v2_q) begin
                     state_d = StCmd58b;
                  end else begin
                     card_hc_d = 1'b0;
                     state_d   = StDone;
                  end
               end else if (!resp_timeout && r1 == R1_IDLE && acmd_cnt_q != AcmdLast) begin
                  acmd_cnt_d = acmd_cnt_q + 1'b1;
                  state_d    = StCmd55;
               end else begin
                  state_d    = StError;
                  err_code_d = ERR_ACMD41;
               end
            end
         end
         StWCmd58b: begin
            if (resp_valid) begin
               if (resp_timeout || r1 != R1_READY) begin
                  state_d    = StError;
                  err_code_d = ERR_CMD58B;
               end else begin
                  card_hc_d = resp_data[30];
                  state_d   = StDone;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      cmd_valid    = 1'b0;
      cmd_frame    = '0;
      cmd_resp_len = '0;
      unique case (state_q)
         StCmd0:   begin cmd_valid = 1'b1; cmd_frame = FRAME_CMD0;  cmd_resp_len = RESP_LEN_R1; end
         StCmd8:   begin cmd_valid = 1'b1; cmd_frame = FRAME_CMD8;  cmd_resp_len = RESP_LEN_R7; end
         StCmd58a,
         StCmd58b: begin cmd_valid = 1'b1; cmd_frame = FRAME_CMD58; cmd_resp_len = RESP_LEN_R7; end
         StCmd55:  begin cmd_valid = 1'b1; cmd_frame = FRAME_CMD55; cmd_resp_len = RESP_LEN_R1; end
         StAcmd41: begin
            cmd_valid    = 1'b1;
            cmd_frame    = card_v2_q ? FRAME_ACMD41_HC : FRAME_ACMD41_SC;
            cmd_resp_len = RESP_LEN_R1;
         end
         default: ;
      endcase
      cs_n       = (state_q == StIdle) || (state_q == StPowerup) || (state_q == StError);
      clk_fast   = (state_q == StDone);
      busy       = !((state_q == StIdle) || (state_q == StDone) || (state_q == StError));
      init_done  = (state_q == StDone);
      init_error = (state_q == StError);
   end

   assign err_code = err_code_q;
   assign card_v2  = card_v2_q;
   assign card_hc  = card_hc_q;

endmodule

// File: tb/tb_sd_init_ctrl.sv
// Bench for sd_init_ctrl: a behavioural SD card answers each accepted frame with randomized
// latency and ready back-pressure; expected outcomes are derived from the scenario description.
module tb_sd_init_ctrl;

   localparam int PWR = 20;
   localparam int C0R = 10;
   localparam int ACR = 8;

   localparam logic [47:0] F_CMD0    = 48'h40_0000_0000_95;
   localparam logic [47:0] F_CMD8    = 48'h48_0000_01AA_87;
   localparam logic [47:0] F_CMD58   = 48'h7A_0000_0000_FD;
   localparam logic [47:0] F_CMD55   = 48'h77_0000_0000_65;
   localparam logic [47:0] F_ACMD_HC = 48'h69_4000_0000_77;
   localparam logic [47:0] F_ACMD_SC = 48'h69_0000_0000_E5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        cmd_ready = 1'b0;
   logic        resp_valid = 1'b0;
   logic        resp_timeout = 1'b0;
   logic [39:0] resp_data = '0;
   logic        cmd_valid, cs_n, clk_fast, busy, init_done, init_error, card_v2, card_hc;
   logic [47:0] cmd_frame;
   logic [5:0]  cmd_resp_len;
   logic [3:0]  err_code;

   always #5 clk = ~clk;

   sd_init_ctrl #(
      .POWERUP_CYCLES(PWR),
      .CMD0_RETRIES  (C0R),
      .ACMD41_RETRIES(ACR)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_frame   (cmd_frame),
      .cmd_resp_len(cmd_resp_len),
      .resp_valid  (resp_valid),
      .resp_timeout(resp_timeout),
      .resp_data   (resp_data),
      .cs_n        (cs_n),
      .clk_fast    (clk_fast),
      .busy        (busy),
      .init_done   (init_done),
      .init_error  (init_error),
      .err_code    (err_code),
      .card_v2     (card_v2),
      .card_hc     (card_hc)
   );

   int vectors = 0;
   int miscompares = 0;

   // Scenario: CMD0 failures before idle, CMD8 kind (0 v2, 1 v1, 2 bad echo),
   // ACMD41 idle replies before ready, CCS, injected fault step (0, 3, 4, 6)
   int sc_cmd0_fail = 0;
   int sc_cmd8_kind = 0;
   int sc_idle_n = 0;
   bit sc_ccs = 1'b0;
   int sc_fault = 0;
   bit sc_hold_ready = 1'b0;
   bit sc_stall_acmd = 1'b0;

   int n_cmd0, n_cmd8, n_cmd58, n_cmd55, n_acmd, n_other;
   logic [47:0] last_acmd;
   int stall_left = 0, stall_cycles = 0, stall_bad = 0, len_bad = 0;
   bit held = 1'b0;
   bit pending = 1'b0;
   int delay = 0;
   logic p_to;
   logic [39:0] p_data;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Card behaviour: choose the reply to one accepted frame
   task automatic answer(input logic [47:0] f);
      p_to   = 1'b0;
      p_data = {8'h00, 32'($urandom())};
      if (f == F_CMD0) begin
         n_cmd0++;
         if (n_cmd0 <= sc_cmd0_fail) begin
            if (sc_cmd0_fail >= C0R || $urandom_range(0, 1) == 1) p_to = 1'b1;
            else p_data[39:32] = 8'h00;
         end else begin
            p_data[39:32] = 8'h01;
         end
      end else if (f == F_CMD8) begin
         n_cmd8++;
         if (sc_cmd8_kind == 0)      p_data = {8'h01, 32'h0000_01AA};
         else if (sc_cmd8_kind == 1) p_data[39:32] = 8'h05;
         else                        p_data = {8'h01, 32'h0000_01AB};
      end else if (f == F_CMD58) begin
         n_cmd58++;
         if (n_cmd58 == 1) begin
            if (sc_fault == 3) p_data[39:32] = 8'h09;
            else p_data[39:32] = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h00;
         end else begin
            p_data[39:32] = (sc_fault == 6) ? 8'h01 : 8'h00;
            p_data[31]    = 1'b1;
            p_data[30]    = sc_ccs;
         end
      end else if (f == F_CMD55) begin
         n_cmd55++;
         if (sc_fault == 4) p_data[39:32] = 8'h04;
         else p_data[39:32] = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h00;
      end else if (f == F_ACMD_HC || f == F_ACMD_SC) begin
         n_acmd++;
         last_acmd     = f;
         p_data[39:32] = (n_acmd <= sc_idle_n) ? 8'h01 : 8'h00;
      end else begin
         n_other++;
      end
   endtask

   // Command engine + card: drives ready/response on falling edges
   initial begin
      forever begin
         @(negedge clk);
         resp_valid   = 1'b0;
         resp_timeout = 1'b0;
         if (!rst_n) begin
            pending = 1'b0;
         end else if (pending) begin
            if (delay == 0) begin
               resp_valid   = 1'b1;
               resp_timeout = p_to;
               resp_data    = p_data;
               pending      = 1'b0;
            end else begin
               delay--;
            end
         end
         if (sc_hold_ready && !held && cmd_valid && cmd_frame == F_CMD8) begin
            held       = 1'b1;
            stall_left = 50;
         end
         if (stall_left > 0) begin
            stall_left--;
            stall_cycles++;
            cmd_ready = 1'b0;
            if (!(cmd_valid && cmd_frame == F_CMD8 && cmd_resp_len == 6'd40)) stall_bad++;
         end else begin
            cmd_ready = ($urandom_range(0, 3) != 0);
         end
         if (rst_n && cmd_valid && cmd_ready) begin
            if ((cmd_frame == F_CMD8 || cmd_frame == F_CMD58) ? (cmd_resp_len != 6'd40)
                                                               : (cmd_resp_len != 6'd8))
               len_bad++;
            answer(cmd_frame);
            if (!(sc_stall_acmd && (cmd_frame == F_ACMD_HC || cmd_frame == F_ACMD_SC))) begin
               pending = 1'b1;
               delay   = $urandom_range(0, 3);
            end
         end
      end
   end

   task automatic set_sc(input int c0, input int k8, input int idle, input bit ccs,
                         input int fault, input bit hold);
      sc_cmd0_fail  = c0;
      sc_cmd8_kind  = k8;
      sc_idle_n     = idle;
      sc_ccs        = ccs;
      sc_fault      = fault;
      sc_hold_ready = hold;
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".cmd_valid"}, 64'(cmd_valid), 64'd0);
      check({tag, ".cmd_frame"}, 64'(cmd_frame), 64'd0);
      check({tag, ".resp_len"},  64'(cmd_resp_len), 64'd0);
      check({tag, ".cs_n"},      64'(cs_n), 64'd1);
      check({tag, ".clk_fast"},  64'(clk_fast), 64'd0);
      check({tag, ".busy"},      64'(busy), 64'd0);
      check({tag, ".done"},      64'(init_done), 64'd0);
      check({tag, ".error"},     64'(init_error), 64'd0);
      check({tag, ".err_code"},  64'(err_code), 64'd0);
      check({tag, ".card_v2"},   64'(card_v2), 64'd0);
      check({tag, ".card_hc"},   64'(card_hc), 64'd0);
   endtask

   // Pulse start, measure the cs_n=1 power-up window, wait (bounded) for the sequence to end
   task automatic run_init(input string tag);
      int pw;
      int cyc;
      n_cmd0 = 0; n_cmd8 = 0; n_cmd58 = 0; n_cmd55 = 0; n_acmd = 0; n_other = 0;
      held = 1'b0; stall_cycles = 0; stall_bad = 0; len_bad = 0;
      last_acmd = '0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, ".busy_after_start"}, 64'(busy), 64'd1);
      pw = 0;
      while (cs_n && busy && pw < PWR + 10) begin
         pw++;
         start = (pw == 3);  // must be ignored while busy
         @(negedge clk);
      end
      start = 1'b0;
      check({tag, ".powerup_len"}, 64'(pw), 64'(PWR));
      cyc = 0;
      while (busy && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, ".finished"}, 64'(cyc < 5000), 64'd1);
   endtask

   // Reference outcome from the scenario rules
   task automatic check_result(input string tag);
      int e_err = 0, e_cmd0, e_cmd8 = 0, e_cmd58 = 0, e_cmd55 = 0, e_acmd = 0;
      bit e_v2 = 1'b0, e_hc = 1'b0, e_done;
      if (sc_cmd0_fail >= C0R) begin
         e_cmd0 = C0R;
         e_err  = 1;
      end else begin
         e_cmd0 = sc_cmd0_fail + 1;
         e_cmd8 = 1;
         if (sc_cmd8_kind == 2) begin
            e_err = 2;
         end else begin
            e_v2    = (sc_cmd8_kind == 0);
            e_cmd58 = 1;
            if (sc_fault == 3) begin
               e_err = 3;
            end else if (sc_fault == 4) begin
               e_cmd55 = 1;
               e_err   = 4;
            end else if (sc_idle_n >= ACR) begin
               e_cmd55 = ACR;
               e_acmd  = ACR;
               e_err   = 5;
            end else begin
               e_cmd55 = sc_idle_n + 1;
               e_acmd  = sc_idle_n + 1;
               if (e_v2) begin
                  e_cmd58 = 2;
                  if (sc_fault == 6) e_err = 6;
                  else               e_hc  = sc_ccs;
               end
            end
         end
      end
      e_done = (e_err == 0);
      check({tag, ".done"},     64'(init_done), 64'(e_done));
      check({tag, ".error"},    64'(init_error), 64'(!e_done));
      check({tag, ".err_code"}, 64'(err_code), 64'(e_err));
      check({tag, ".card_v2"},  64'(card_v2), 64'(e_v2));
      check({tag, ".card_hc"},  64'(card_hc), 64'(e_hc));
      check({tag, ".clk_fast"}, 64'(clk_fast), 64'(e_done));
      check({tag, ".cs_n"},     64'(cs_n), 64'(!e_done));
      check({tag, ".n_cmd0"},   64'(n_cmd0), 64'(e_cmd0));
      check({tag, ".n_cmd8"},   64'(n_cmd8), 64'(e_cmd8));
      check({tag, ".n_cmd58"},  64'(n_cmd58), 64'(e_cmd58));
      check({tag, ".n_cmd55"},  64'(n_cmd55), 64'(e_cmd55));
      check({tag, ".n_acmd41"}, 64'(n_acmd), 64'(e_acmd));
      check({tag, ".n_unknown"}, 64'(n_other), 64'd0);
      check({tag, ".resp_len"}, 64'(len_bad), 64'd0);
      if (e_acmd > 0)
         check({tag, ".acmd41_frame"}, 64'(last_acmd), 64'(e_v2 ? F_ACMD_HC : F_ACMD_SC));
      if (sc_hold_ready) begin
         check({tag, ".stall_cycles"}, 64'(stall_cycles), 64'd50);
         check({tag, ".stall_stable"}, 64'(stall_bad), 64'd0);
      end
   endtask

   initial begin
      int wait_cyc;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_no_start.busy", 64'(busy), 64'd0);

      set_sc(0, 0, 2, 1'b1, 0, 1'b0); run_init("v2_sdhc");     check_result("v2_sdhc");
      set_sc(0, 1, 0, 1'b0, 0, 1'b0); run_init("v1_card");     check_result("v1_card");
      set_sc(100, 0, 0, 1'b0, 0, 1'b0); run_init("cmd0_to");   check_result("cmd0_to");
      set_sc(0, 2, 0, 1'b0, 0, 1'b0); run_init("cmd8_bad");    check_result("cmd8_bad");
      set_sc(1, 0, 1, 1'b0, 0, 1'b1); run_init("rerun_hold");  check_result("rerun_hold");
      set_sc(9, 0, 0, 1'b1, 0, 1'b0); run_init("cmd0_last");   check_result("cmd0_last");
      set_sc(0, 0, 0, 1'b0, 3, 1'b0); run_init("cmd58a_err");  check_result("cmd58a_err");
      set_sc(0, 1, 0, 1'b0, 4, 1'b0); run_init("cmd55_err");   check_result("cmd55_err");
      set_sc(0, 0, 1, 1'b1, 6, 1'b0); run_init("cmd58b_err");  check_result("cmd58b_err");
      set_sc(0, 0, ACR, 1'b0, 0, 1'b0); run_init("acmd_lim");  check_result("acmd_lim");
      set_sc(0, 1, ACR - 1, 1'b0, 0, 1'b0); run_init("acmd_last"); check_result("acmd_last");

      for (int i = 0; i < 8; i++) begin
         int f;
         f = $urandom_range(0, 4);
         set_sc($urandom_range(0, 3), $urandom_range(0, 3) % 3, $urandom_range(0, 3),
                1'($urandom_range(0, 1)), (f == 2) ? 3 : (f == 3) ? 4 : (f == 4) ? 6 : 0,
                1'($urandom_range(0, 1)));
         run_init($sformatf("rand%0d", i));
         check_result($sformatf("rand%0d", i));
      end

      // Reset pulse while waiting for an ACMD41 reply that never comes
      set_sc(0, 0, 0, 1'b1, 0, 1'b0);
      sc_stall_acmd = 1'b1;
      n_acmd = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_cyc = 0;
      while (n_acmd == 0 && wait_cyc < 2000) begin
         @(negedge clk);
         wait_cyc++;
      end
      check("mid_reset.reached_acmd41", 64'(n_acmd), 64'd1);
      repeat (2) @(negedge clk);
      check("mid_reset.busy_before", 64'(busy), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check_reset("mid_reset");
      rst_n = 1'b1;
      sc_stall_acmd = 1'b0;
      run_init("after_reset");
      check_result("after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
